// File: rtl/pair_feeder.sv
// Pair feeder: enumerates reference/neighbor particle pairs for one cell pair and
// streams one 194-bit pair packet per clock into the force pipeline.
module pair_feeder #(
    parameter int ADDR_W = 8,
    parameter int POS_W  = 96
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 home_cell,
    input  logic [ADDR_W:0]      ref_count,
    input  logic [ADDR_W:0]      nbr_count,
    output logic [ADDR_W-1:0]    ref_addr,
    input  logic [POS_W-1:0]     ref_data,
    output logic [ADDR_W-1:0]    nbr_addr,
    input  logic [POS_W-1:0]     nbr_data,
    output logic [2*POS_W+1:0]   out,
    output logic                 busy,
    output logic                 done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int PKT_W = 2 * POS_W + 2;
    localparam logic [PKT_W-1:0] NULL_PKT = {1'b1, {(PKT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   i_q, i_d, j_q, j_d;
    logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d, nbr_cnt_q, nbr_cnt_d;
    logic               home_q, home_d;
    logic [ADDR_W-1:0]  ref_addr_q, ref_addr_d, nbr_addr_q, nbr_addr_d;
    logic               issue_valid_q, issue_valid_d;
    logic [PKT_W-1:0]   out_q, out_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               accept, empty;
    logic [CNT_W-1:0]   i_n, j_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            ref_cnt_q     <= '0;
            nbr_cnt_q     <= '0;
            home_q        <= 1'b0;
            ref_addr_q    <= '0;
            nbr_addr_q    <= '0;
            issue_valid_q <= 1'b0;
            out_q         <= NULL_PKT;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            ref_cnt_q     <= ref_cnt_d;
            nbr_cnt_q     <= nbr_cnt_d;
            home_q        <= home_d;
            ref_addr_q    <= ref_addr_d;
            nbr_addr_q    <= nbr_addr_d;
            issue_valid_q <= issue_valid_d;
            out_q         <= out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // busy_q also covers the done cycle, so a start there is ignored
    assign accept = start && (state_q == IDLE) && !busy_q;
    assign empty  = (ref_count == '0) || (nbr_count == '0) ||
                    (home_cell && (ref_count <= CNT_W'(1)));

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        ref_cnt_d = ref_cnt_q;
        nbr_cnt_d = nbr_cnt_q;
        home_d    = home_q;
        i_n       = i_q;
        j_n       = j_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ref_cnt_d = ref_count;
                    nbr_cnt_d = nbr_count;
                    home_d    = home_cell;
                    i_d       = '0;
                    j_d       = home_cell ? CNT_W'(1) : '0;
                    state_d   = empty ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (j_n == nbr_cnt_q) begin
                    i_n = i_q + CNT_W'(1);
                    j_n = home_q ? i_n + CNT_W'(1) : '0;
                end
                i_d = i_n;
                j_d = j_n;
                // Home passes run out when the upper triangle's last row is empty
                if ((i_n == ref_cnt_q) || (j_n >= nbr_cnt_q))
                    state_d = DRAIN;
            end
            DRAIN:   state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ref_addr_d    = ref_addr_q;
        nbr_addr_d    = nbr_addr_q;
        issue_valid_d = 1'b0;
        if (state_q == ISSUE) begin
            ref_addr_d    = i_q[ADDR_W-1:0];
            nbr_addr_d    = j_q[ADDR_W-1:0];
            issue_valid_d = 1'b1;
        end
        out_d  = issue_valid_q ? {1'b0, nbr_data, 1'b0, ref_data} : NULL_PKT;
        done_d = (state_q == FIN);
        busy_d = busy_q;
        if (accept)
            busy_d = 1'b1;
        else if (done_q)
            busy_d = 1'b0;
    end

    assign ref_addr = ref_addr_q;
    assign nbr_addr = nbr_addr_q;
    assign out      = out_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_pair_feeder.sv
// Scoreboard bench for pair_feeder: stimulus pushes hand-listed pair packets,
// a negedge monitor pops and compares every real packet seen on out.
module tb_pair_feeder;
    localparam int ADDR_W = 8;
    localparam logic [193:0] NULL_PKT = {1'b1, 193'b0};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              home_cell = 1'b0;
    logic [ADDR_W:0]   ref_count = '0;
    logic [ADDR_W:0]   nbr_count = '0;
    logic [ADDR_W-1:0] ref_addr, nbr_addr;
    logic [95:0]       ref_data, nbr_data;
    logic [193:0]      out;
    logic              busy, done;

    int tests = 0;
    int fails = 0;
    logic [193:0] sb[$];

    pair_feeder #(.ADDR_W(ADDR_W), .POS_W(96)) dut (
        .clk(clk), .reset(reset), .start(start), .home_cell(home_cell),
        .ref_count(ref_count), .nbr_count(nbr_count),
        .ref_addr(ref_addr), .ref_data(ref_data),
        .nbr_addr(nbr_addr), .nbr_data(nbr_data),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cache models: data follows the registered address within the same cycle
    assign ref_data = 96'hA0 + 96'(ref_addr);
    assign nbr_data = 96'hB0 + 96'(nbr_addr);

    task automatic check(input string name, input logic [193:0] act, input logic [193:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input int j);
        sb.push_back({1'b0, 96'hB0 + 96'(j), 1'b0, 96'hA0 + 96'(i)});
    endtask

    always @(negedge clk) begin
        if (out[193] === 1'b0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pkt: got %h expected none", out);
            end else begin
                check("pkt", out, sb.pop_front());
            end
        end else if (!reset) begin
            check("null_pkt", out, NULL_PKT);
        end
    end

    // Starts a pass; exp_done is the negedge index (1 = first after accept) of done
    task automatic do_pass(input bit home, input int rc, input int nc, input int exp_done,
                           input bit poke_mid, input bit poke_done);
        int done_at;
        int busy_n;
        @(negedge clk);
        check("idle_busy", 194'(busy), 194'(0));
        check("idle_done", 194'(done), 194'(0));
        start = 1'b1; home_cell = home;
        ref_count = 9'(rc); nbr_count = 9'(nc);
        done_at = 0; busy_n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (poke_mid && k == 3) begin
                start = 1'b1; home_cell = 1'b1; ref_count = 9'd5; nbr_count = 9'd5;
            end else begin
                start = 1'b0; home_cell = 1'($urandom); ref_count = 9'($urandom); nbr_count = 9'($urandom);
            end
            if (busy) busy_n++;
            if (done) begin
                done_at = k;
                break;
            end
        end
        check("done_cycle", 194'(done_at), 194'(exp_done));
        check("busy_cycles", 194'(busy_n), 194'(exp_done));
        check("out_null_at_done", out, NULL_PKT);
        check("sb_drained", 194'(sb.size()), 194'(0));
        if (poke_done) begin
            start = 1'b1; home_cell = 1'b0; ref_count = 9'd1; nbr_count = 9'd1;
        end
    endtask

    initial begin
        // Reset held with start toggling
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = ~start;
            check("rst_out", out, NULL_PKT);
            check("rst_busy", 194'(busy), 194'(0));
            check("rst_done", 194'(done), 194'(0));
            check("rst_addr", 194'({ref_addr, nbr_addr}), 194'(0));
        end
        start = 1'b0;
        reset = 1'b0;

        // 2x3 non-home, mid-pass start ignored, start during done cycle ignored
        push(0,0); push(0,1); push(0,2); push(1,0); push(1,1); push(1,2);
        do_pass(1'b0, 2, 3, 9, 1'b1, 1'b1);
        // Home pass of 4, started the cycle after done
        push(0,1); push(0,2); push(0,3); push(1,2); push(1,3); push(2,3);
        do_pass(1'b1, 4, 4, 9, 1'b0, 1'b0);
        // Empty passes
        do_pass(1'b0, 0, 3, 2, 1'b0, 1'b0);
        do_pass(1'b1, 1, 1, 2, 1'b0, 1'b0);
        // Single-pair boundaries
        push(0,0);
        do_pass(1'b0, 1, 1, 4, 1'b0, 1'b0);
        push(0,1);
        do_pass(1'b1, 2, 2, 4, 1'b0, 1'b0);

        // Reset on the 3rd packet of a 2x3 pass
        push(0,0); push(0,1); push(0,2); push(1,0); push(1,1); push(1,2);
        @(negedge clk);
        start = 1'b1; home_cell = 1'b0; ref_count = 9'd2; nbr_count = 9'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("rst_mid_out", out, NULL_PKT);
        check("rst_mid_busy", 194'(busy), 194'(0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_mid_no_done", 194'(done), 194'(0));
        end

        // Full pass after the abort
        push(0,0); push(0,1); push(0,2); push(1,0); push(1,1); push(1,2);
        do_pass(1'b0, 2, 3, 9, 1'b0, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
